// File: rtl/icache_pkg.sv
// Shared parameters and state encoding for the instruction cache.
package icache_pkg;

  localparam int unsigned ADDR_WIDTH   = 32;
  localparam int unsigned INSTR_WIDTH  = 32;

  // 64 one-word lines; tag taken from address bits [17:8].
  localparam int unsigned IC_LINE_BITS = 6;
  localparam int unsigned IC_TAG_BITS  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    RESP = 2'd2
  } ic_state_e;

endpackage

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache between iFetch and memCtrl.
// Hits answer one cycle after the request; misses hold a fill request to
// memCtrl until it completes, then answer with the fill word.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned LINE_BITS = IC_LINE_BITS,
  parameter int unsigned TAG_BITS  = IC_TAG_BITS
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   roll_back,
  input  logic                   if_in_en,
  input  logic [ADDR_WIDTH-1:0]  if_ain,
  output logic                   if_out_en,
  output logic [INSTR_WIDTH-1:0] if_instr_out,
  output logic                   mc_aout_en,
  output logic [ADDR_WIDTH-1:0]  mc_aout,
  input  logic                   mc_instr_in_en,
  input  logic [INSTR_WIDTH-1:0] mc_instr_in
);

  localparam int unsigned LINES   = 1 << LINE_BITS;
  localparam int unsigned TAG_LSB = LINE_BITS + 2;

  logic [LINES-1:0]       valid_q;
  logic [TAG_BITS-1:0]    tag_mem  [LINES];
  logic [INSTR_WIDTH-1:0] data_mem [LINES];

  ic_state_e              state_q, state_d;
  logic                   if_out_en_d;
  logic [INSTR_WIDTH-1:0] if_instr_d;
  logic                   mc_aout_en_d;
  logic [ADDR_WIDTH-1:0]  mc_aout_d;
  logic                   fill_we;

  logic [LINE_BITS-1:0]   req_idx, fill_idx;
  logic [TAG_BITS-1:0]    req_tag, fill_tag;
  logic                   req_hit;

  // The held fill address in mc_aout doubles as the latched miss address.
  assign req_idx  = if_ain[LINE_BITS+1:2];
  assign req_tag  = if_ain[TAG_LSB +: TAG_BITS];
  assign fill_idx = mc_aout[LINE_BITS+1:2];
  assign fill_tag = mc_aout[TAG_LSB +: TAG_BITS];
  assign req_hit  = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  // Next-state and next-output logic; roll_back overrides every other event.
  always_comb begin
    state_d      = state_q;
    if_out_en_d  = 1'b0;
    if_instr_d   = if_instr_out;
    mc_aout_en_d = mc_aout_en;
    mc_aout_d    = mc_aout;
    fill_we      = 1'b0;
    if (roll_back) begin
      state_d      = IDLE;
      mc_aout_en_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (if_in_en) begin
            if (req_hit) begin
              state_d     = RESP;
              if_out_en_d = 1'b1;
              if_instr_d  = data_mem[req_idx];
            end else begin
              state_d      = MISS;
              mc_aout_en_d = 1'b1;
              mc_aout_d    = if_ain;
            end
          end
        end
        MISS: begin
          if (mc_instr_in_en) begin
            fill_we      = 1'b1;
            state_d      = RESP;
            mc_aout_en_d = 1'b0;
            if_out_en_d  = 1'b1;
            if_instr_d   = mc_instr_in;
          end
        end
        RESP: begin
          state_d = IDLE;
        end
        default: begin
          state_d      = IDLE;
          mc_aout_en_d = 1'b0;
        end
      endcase
    end
  end

  // State, registered outputs and valid bits; everything holds while rdy_in is low.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      if_out_en    <= 1'b0;
      if_instr_out <= '0;
      mc_aout_en   <= 1'b0;
      mc_aout      <= '0;
      valid_q      <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      if_out_en    <= if_out_en_d;
      if_instr_out <= if_instr_d;
      mc_aout_en   <= mc_aout_en_d;
      mc_aout      <= mc_aout_d;
      if (fill_we) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays; a fill overwrites the line whatever tag it held.
  always_ff @(posedge clk) begin
    if (rdy_in && fill_we) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mc_instr_in;
    end
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- LINE_BITS, 6, log2 of line count (64 one-word lines).
- TAG_BITS, 10, tag width taken from address bits [17:8].
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  system clock; one clock domain.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global ready; low freezes all state.
- roll_back  in  1  ROB misprediction flush.
- if_in_en  in  1  fetch request strobe from iFetch, one-cycle pulse.
- if_ain  in  32  fetch address, word-aligned.
- if_out_en  out  1  instruction valid to iFetch, one-cycle pulse.
- if_instr_out  out  32  returned instruction.
- mc_aout_en  out  1  line-fill request to memCtrl, level.
- mc_aout  out  32  line-fill address.
- mc_instr_in_en  in  1  memCtrl fill complete, one-cycle pulse.
- mc_instr_in  in  32  fill data.

Function
REQ-003 Storage SHALL be direct-mapped, 2^LINE_BITS lines, each holding valid bit, TAG_BITS tag and a 32-bit word; index = if_ain[LINE_BITS+1:2], tag = if_ain[17:8].
REQ-004 The FSM SHALL have three states: IDLE, MISS, RESP.
REQ-005 IDLE: on if_in_en with a hit, SHALL latch the word and go to RESP; on a miss, SHALL latch address, assert mc_aout_en with mc_aout = if_ain, and go to MISS.
REQ-006 RESP: SHALL drive if_out_en=1 and if_instr_out for exactly one cycle, then return to IDLE; hit latency is request cycle + 1.
REQ-007 MISS: mc_aout_en and mc_aout SHALL remain stable until mc_instr_in_en; in that cycle it SHALL write valid/tag/word for the latched index, deassert mc_aout_en and go to RESP with mc_instr_in.
REQ-008 if_in_en outside IDLE SHALL be ignored; iFetch issues no new request until if_out_en.
REQ-009 roll_back SHALL take priority over every other event: next state IDLE, mc_aout_en=0, if_out_en=0, no array write, even if mc_instr_in_en arrives in the same cycle.
REQ-010 if_in_en in the cycle roll_back is high SHALL be ignored.
REQ-011 A fill SHALL overwrite the indexed line unconditionally (aliased tag replaced).
REQ-012 While rdy_in=0, all registers, array contents and outputs SHALL hold; input pulses in such cycles are ignored.
REQ-013 if_out_en SHALL be 0 in IDLE and MISS; mc_aout_en SHALL be 0 in IDLE and RESP.

Reset
REQ-014 While rst_in=0: state IDLE, all valid bits 0, if_out_en=0, if_instr_out=0, mc_aout_en=0, mc_aout=0; tag/data arrays need not be cleared.
REQ-015 Reset during MISS SHALL abandon the fill with no array write; first post-reset request SHALL miss.

Structure
REQ-016 LINE_BITS, TAG_BITS and FSM state encodings SHALL live in the shared parameter include alongside ADDR_WIDTH/INSTR_WIDTH.
REQ-017 The block SHALL be one module with no sub-modules; arrays are plain register arrays, instantiated in cpu between Ifetch and MemCtrl on the if/mc handshake.

Verification
REQ-018 Cold miss: request 0x00000004, memCtrl returns 0x00000013 after 5 cycles -> mc_aout=0x4 held 5 cycles, if_out_en one cycle later with 0x00000013.
REQ-019 Hit: repeat request 0x00000004 -> if_out_en next cycle with 0x00000013, mc_aout_en stays 0.
REQ-020 Aliasing: fill 0x00000004 then request 0x00000104 (same index, tag differs) -> miss, fill replaces line; re-request 0x00000004 misses again.
REQ-021 Flush: request 0x00000008 miss, roll_back in the same cycle as mc_instr_in_en -> no if_out_en, re-request 0x00000008 misses.
REQ-022 Stall: rdy_in=0 for 3 cycles during RESP -> if_out_en held, then released exactly one cycle after rdy_in=1.
REQ-023 Reset mid-MISS: rst_in=0 while mc_aout_en=1 -> mc_aout_en=0 immediately (asynchronous); post-reset request to same address misses.
